// File: rtl/selector_bus_rtc_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : selector_bus_rtc_arb_if
// Brief    : Request/data bundle between the requesting sub-blocks and the RTC bus arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface selector_bus_rtc_arb_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
);
  logic [N_CH-1:0]       req;
  logic [N_CH*WIDTH-1:0] bus_in;
  logic [WIDTH-1:0]      Bus_Direcciones_Datos;
  logic [N_CH-1:0]       grant;
  logic                  bus_valid;
  logic                  busy;

  // master: the arbiter itself; slave: the requesting channels.
  modport master (
    input  req, bus_in,
    output Bus_Direcciones_Datos, grant, bus_valid, busy
  );
  modport slave (
    output req, bus_in,
    input  Bus_Direcciones_Datos, grant, bus_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/selector_bus_rtc_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : selector_bus_rtc_arb
// Brief    : Registered N-channel arbiter/mux for the RTC address/data bus.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module selector_bus_rtc_arb #(
  parameter int               WIDTH      = 8,
  parameter int               N_CH       = 4,
  parameter int               MODE       = 0,
  parameter int               TURNAROUND = 1,
  parameter int               HOLD_LAST  = 1,
  parameter logic [WIDTH-1:0] IDLE_VAL   = {WIDTH{1'b0}}
) (
  input  wire logic                    clk,
  input  wire logic                    reset_n,
  selector_bus_rtc_arb_if.master       sb
);

  localparam int               c_IW      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [3:0]       c_TA      = 4'(TURNAROUND);
  localparam logic [WIDTH-1:0] c_RST_BUS = (HOLD_LAST != 0) ? {WIDTH{1'b0}} : IDLE_VAL;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_IW-1:0]   r_owner, w_owner_nxt;
  logic [c_IW-1:0]   r_last, w_last_nxt;
  logic [c_IW-1:0]   w_win, w_idx;
  logic              w_found;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]  r_bus, w_bus_nxt;
  logic [N_CH-1:0]   r_grant, w_grant_nxt;
  logic              r_busy, w_busy_nxt;
  logic [WIDTH-1:0]  w_ch [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign w_ch[g] = sb.bus_in[g*WIDTH +: WIDTH];
  end

  // Winner search: fixed order from 0, or rotating from the channel after the last owner.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (MODE == 0) w_idx = c_IW'(i);
      else           w_idx = c_IW'((int'(r_last) + 1 + i) % N_CH);
      if (!w_found && sb.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_bus_nxt   = r_bus;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt        = S_OWN;
          w_owner_nxt        = w_win;
          w_last_nxt         = w_win;
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
          w_busy_nxt         = 1'b1;
          w_bus_nxt          = w_ch[w_win];
        end else if (HOLD_LAST == 0) begin
          w_bus_nxt = IDLE_VAL;
        end
      end
      S_OWN: begin
        if (sb.req[r_owner]) begin
          w_bus_nxt = w_ch[r_owner];
        end else begin
          w_grant_nxt = '0;
          if (HOLD_LAST == 0) w_bus_nxt = IDLE_VAL;
          if (TURNAROUND > 0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = c_TA - 4'd1;
          end else begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= c_IW'(N_CH - 1);
      r_cnt   <= 4'd0;
      r_bus   <= c_RST_BUS;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bus   <= w_bus_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign sb.Bus_Direcciones_Datos = r_bus;
  assign sb.grant                 = r_grant;
  assign sb.bus_valid             = |r_grant;
  assign sb.busy                  = r_busy;

endmodule
`default_nettype wire
